// File: rtl/not_pipe.sv
// not_pipe: selectable bitwise NOT on a valid/ready stream through a
// STAGES-deep register pipeline, with a saturating count of inverted words.
module not_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_mask,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] inv_count
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ALL  = 2'b01;
  localparam logic [1:0] MODE_MASK = 2'b10;

  // Constant with every odd-index bit set (8'hAA for WIDTH=8).
  function automatic logic [WIDTH-1:0] odd_bits();
    logic [WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      p[i] = 1'(i % 2);
    end
    return p;
  endfunction

  localparam logic [WIDTH-1:0] ODD_MASK = odd_bits();
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  xform;
  logic              in_xfer;

  // Word transform applied on the way into stage 1.
  always_comb begin
    xform = in_data;
    case (in_mode)
      MODE_PASS: xform = in_data;
      MODE_ALL:  xform = ~in_data;
      MODE_MASK: xform = in_data ^ in_mask;
      default:   xform = in_data ^ ODD_MASK;
    endcase
  end

  // Ready chain: stage k vacates when any stage below it is empty or the
  // consumer takes the last one, so back-to-back words flow without bubbles.
  always_comb begin
    logic full_below;
    adv = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      full_below = 1'b1;
      for (int j = k + 1; j < int'(STAGES); j++) begin
        full_below = full_below & stage_valid[j];
      end
      adv[k] = out_ready | ~full_below;
    end
  end

  assign in_ready  = ~stage_valid[0] | adv[0];
  assign in_xfer   = in_valid & in_ready;
  assign out_data  = stage_data[STAGES-1];
  assign out_valid = stage_valid[STAGES-1];

  // Pipeline registers; data only moves when its source holds a valid word.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      if (~stage_valid[0] | adv[0]) begin
        stage_valid[0] <= in_xfer;
        if (in_xfer) begin
          stage_data[0] <= xform;
        end
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (~stage_valid[k] | adv[k]) begin
          stage_valid[k] <= stage_valid[k-1];
          if (stage_valid[k-1]) begin
            stage_data[k] <= stage_data[k-1];
          end
        end
      end
    end
  end

  // Saturating count of accepted words whose mode modifies the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      inv_count <= '0;
    end else if (in_xfer && (in_mode != MODE_PASS) && (inv_count != CNT_MAX)) begin
      inv_count <= inv_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_not_pipe.sv
// Directed bench for not_pipe: default config, a narrow-counter config and
// a WIDTH=1/STAGES=1 config.
module tb_not_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [7:0]  a_in_data, a_in_mask, a_out_data;
  logic [1:0]  a_in_mode;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_inv_count;

  logic [7:0]  s_in_data, s_in_mask, s_out_data;
  logic [1:0]  s_in_mode;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [2:0]  s_inv_count;

  logic        w_in_data, w_in_mask, w_out_data;
  logic [1:0]  w_in_mode;
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [15:0] w_inv_count;

  not_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_mode(a_in_mode),
    .in_mask(a_in_mask), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .inv_count(a_inv_count));

  not_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .in_data(s_in_data), .in_mode(s_in_mode),
    .in_mask(s_in_mask), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .inv_count(s_inv_count));

  not_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) dut_w (
    .clk(clk), .reset(reset), .in_data(w_in_data), .in_mode(w_in_mode),
    .in_mask(w_in_mask), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .inv_count(w_inv_count));

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic [7:0] mask;
    logic [7:0] expd;
  } vec_t;

  vec_t vecs [6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent reference transform for the 8-bit instance.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] m, input logic [7:0] k);
    case (m)
      2'b00:   return d;
      2'b01:   return 8'hFF - d;
      2'b10:   return d ^ k;
      default: return d ^ 8'b1010_1010;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    a_in_valid = 1'b0; s_in_valid = 1'b0; w_in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_group(input int lo, input int hi, input logic [15:0] exp_cnt);
    do_reset();
    a_out_ready = 1'b1;
    for (int i = lo; i <= hi + 2; i++) begin
      a_in_valid = (i <= hi);
      if (i <= hi) begin
        a_in_data = vecs[i].data;
        a_in_mode = vecs[i].mode;
        a_in_mask = vecs[i].mask;
      end
      #1;
      check("grp_in_ready", 32'(a_in_ready), 32'd1);
      if (i == lo + 1) check("grp_first_latency", 32'(a_out_valid), 32'd0);
      if (i >= lo + 2) begin
        check("grp_out_valid", 32'(a_out_valid), 32'd1);
        check("grp_out_data", 32'(a_out_data), 32'(vecs[i-2].expd));
      end
      tick();
    end
    check("grp_out_drained", 32'(a_out_valid), 32'd0);
    check("grp_inv_count", 32'(a_inv_count), 32'(exp_cnt));
  endtask

  logic [7:0] bw [4];
  logic [7:0] q [$];

  initial begin
    int idx;
    int sent;
    int cyc;
    logic seen;
    logic [7:0] d, k, e;
    logic [1:0] m;

    vecs[0] = '{8'h00, 2'b01, 8'h00, 8'hFF};
    vecs[1] = '{8'h5A, 2'b01, 8'h00, 8'hA5};
    vecs[2] = '{8'hFF, 2'b01, 8'h00, 8'h00};
    vecs[3] = '{8'h0F, 2'b00, 8'h00, 8'h0F};
    vecs[4] = '{8'h0F, 2'b10, 8'h3C, 8'h33};
    vecs[5] = '{8'h0F, 2'b11, 8'h00, 8'hA5};

    reset = 1'b1;
    a_in_data = '0; a_in_mode = '0; a_in_mask = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    s_in_data = '0; s_in_mode = '0; s_in_mask = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    w_in_data = '0; w_in_mode = '0; w_in_mask = '0; w_in_valid = 1'b0; w_out_ready = 1'b0;

    // Reset state.
    do_reset();
    #1;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_inv_count", 32'(a_inv_count), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);

    // Streaming and mode coverage tables.
    run_group(0, 2, 16'd3);
    run_group(3, 5, 16'd2);

    // Backpressure: two accepted, then stall; release drains four in order.
    do_reset();
    a_out_ready = 1'b0;
    bw[0] = 8'h11; bw[1] = 8'h22; bw[2] = 8'h33; bw[3] = 8'h44;
    a_in_mode = 2'b01;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = bw[idx];
      #1;
      check("bp_in_ready", 32'(a_in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (a_in_ready) idx++;
      tick();
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_hold_valid", 32'(a_out_valid), 32'd1);
    check("bp_hold_data", 32'(a_out_data), 32'hEE);
    a_out_ready = 1'b1;
    a_in_data   = bw[idx];
    #1;
    check("bp_ready_rise", 32'(a_in_ready), 32'd1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin
        a_in_valid = (idx < 4);
        if (idx < 4) a_in_data = bw[idx];
        #1;
      end
      check("bp_drain_valid", 32'(a_out_valid), 32'd1);
      check("bp_drain_data", 32'(a_out_data), 32'(model(bw[j], 2'b01, 8'h00)));
      if (a_in_valid && a_in_ready) idx++;
      tick();
    end
    a_in_valid = 1'b0;
    #1;
    check("bp_all_in", 32'(idx), 32'd4);
    check("bp_empty", 32'(a_out_valid), 32'd0);

    // Full pipeline with simultaneous accept and emit, random words.
    do_reset();
    q.delete();
    a_out_ready = 1'b0;
    sent = 0;
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom); m = 2'($urandom); k = 8'($urandom);
      a_in_valid = 1'b1; a_in_data = d; a_in_mode = m; a_in_mask = k;
      #1;
      check("full_fill_ready", 32'(a_in_ready), 32'd1);
      q.push_back(model(d, m, k));
      sent++;
      tick();
    end
    a_out_ready = 1'b1;
    cyc = 0;
    while ((sent < 20 || q.size() > 0) && cyc < 60) begin
      a_in_valid = (sent < 20);
      if (sent < 20) begin
        d = 8'($urandom); m = 2'($urandom); k = 8'($urandom);
        a_in_data = d; a_in_mode = m; a_in_mask = k;
      end
      #1;
      if (sent < 20) check("full_in_ready", 32'(a_in_ready), 32'd1);
      check("full_out_valid", 32'(a_out_valid), 32'd1);
      if (a_out_valid) begin
        e = q.pop_front();
        check("full_out_data", 32'(a_out_data), 32'(e));
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back(model(d, m, k));
        sent++;
      end
      tick();
      cyc++;
    end
    check("full_budget", (cyc < 60) ? 32'd1 : 32'd0, 32'd1);
    a_in_valid = 1'b0;
    #1;
    check("full_empty", 32'(a_out_valid), 32'd0);

    // Reset with two words in flight discards them.
    do_reset();
    a_out_ready = 1'b0;
    a_in_mode = 2'b01;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(i + 3);
      tick();
    end
    a_in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_count", 32'(a_inv_count), 32'd0);
    a_out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_out_valid) seen = 1'b1;
    end
    check("mid_rst_no_emit", 32'(seen), 32'd0);

    // Counter saturation on the 3-bit instance.
    do_reset();
    s_out_ready = 1'b1;
    s_in_mode = 2'b01;
    for (int i = 0; i < 10; i++) begin
      s_in_valid = 1'b1; s_in_data = 8'(i);
      tick();
      check("sat_count", 32'(s_inv_count), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end
    s_in_valid = 1'b0;
    tick();
    check("sat_hold", 32'(s_inv_count), 32'd7);

    // WIDTH=1, STAGES=1: one-edge latency.
    do_reset();
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_data = 1'b0; w_in_mode = 2'b01;
    #1;
    check("w1_in_ready", 32'(w_in_ready), 32'd1);
    check("w1_pre_valid", 32'(w_out_valid), 32'd0);
    tick();
    w_in_valid = 1'b0;
    #1;
    check("w1_out_valid", 32'(w_out_valid), 32'd1);
    check("w1_out_data", 32'(w_out_data), 32'd1);
    check("w1_count", 32'(w_inv_count), 32'd1);
    tick();
    check("w1_drained", 32'(w_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
